// File: rtl/lc3b_types.sv
// Shared types for the wishbone round-robin memory arbiter: FSM states,
// requester indices and small index helpers.
package lc3b_types;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  typedef logic [1:0] arb_req_t;

  localparam int unsigned NUM_REQ = 3;

  localparam arb_req_t REQ_IC = 2'd0;
  localparam arb_req_t REQ_DC = 2'd1;
  localparam arb_req_t REQ_PF = 2'd2;

  function automatic logic [NUM_REQ-1:0] req_onehot(input arb_req_t idx);
    logic [NUM_REQ-1:0] one;
    one = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  function automatic arb_req_t req_after(input arb_req_t base, input int unsigned step);
    return arb_req_t'((32'(base) + step) % NUM_REQ);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: nearest requester after last_owner wins,
// last_owner itself has lowest priority.
module rr_pick
  import lc3b_types::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  arb_req_t           last_owner,
  output logic [NUM_REQ-1:0] gnt,
  output arb_req_t           idx
);

  arb_req_t cand;

  always_comb begin
    gnt  = '0;
    idx  = REQ_IC;
    cand = REQ_IC;
    // Farthest candidate first, so the nearest hit overwrites and wins.
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = req_after(last_owner, k);
      if (req[cand]) begin
        gnt = req_onehot(cand);
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Three-requester wishbone arbiter (icache, dcache, prefetcher) onto one memory
// port: round-robin ownership, one-cycle release gap, abort and timeout handling.
module wb_rr_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         rst_n,

  input  logic         icache_arb_cyc,
  input  logic         icache_arb_stb,
  input  logic [11:0]  icache_arb_adr,
  input  logic [15:0]  icache_arb_sel,
  input  logic [127:0] icache_arb_dat_m,
  output logic [127:0] icache_arb_dat_s,
  output logic         icache_arb_ack,
  output logic         icache_arb_rty,

  input  logic         dcache_arb_cyc,
  input  logic         dcache_arb_stb,
  input  logic         dcache_arb_we,
  input  logic [11:0]  dcache_arb_adr,
  input  logic [15:0]  dcache_arb_sel,
  input  logic [127:0] dcache_arb_dat_m,
  output logic [127:0] dcache_arb_dat_s,
  output logic         dcache_arb_ack,
  output logic         dcache_arb_rty,

  input  logic         pf_arb_cyc,
  input  logic         pf_arb_stb,
  input  logic [11:0]  pf_arb_adr,
  input  logic [15:0]  pf_arb_sel,
  input  logic [127:0] pf_arb_dat_m,
  output logic [127:0] pf_arb_dat_s,
  output logic         pf_arb_ack,
  output logic         pf_arb_rty,

  output logic         arb_mem_cyc,
  output logic         arb_mem_stb,
  output logic         arb_mem_we,
  output logic [11:0]  arb_mem_adr,
  output logic [15:0]  arb_mem_sel,
  output logic [127:0] arb_mem_dat_m,
  input  logic [127:0] arb_mem_dat_s,
  input  logic         arb_mem_ack,

  output logic [2:0]   grant,
  output logic         timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  arb_req_t            owner_q, owner_d;
  arb_req_t            last_owner_q, last_owner_d;
  logic [CW-1:0]       wait_q, wait_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  req_stb;
  logic [NUM_REQ-1:0]  pick_gnt;
  arb_req_t            pick_idx;

  logic                in_grant;
  logic                own_stb;
  logic                own_cyc;
  logic                ack_fwd;

  assign req_stb = {pf_arb_stb, dcache_arb_stb, icache_arb_stb};

  rr_pick u_pick (
    .req        (req_stb),
    .last_owner (last_owner_q),
    .gnt        (pick_gnt),
    .idx        (pick_idx)
  );

  always_comb begin
    unique case (owner_q)
      REQ_IC: begin
        own_stb       = icache_arb_stb;
        own_cyc       = icache_arb_cyc;
        arb_mem_adr   = icache_arb_adr;
        arb_mem_sel   = icache_arb_sel;
        arb_mem_dat_m = icache_arb_dat_m;
      end
      REQ_DC: begin
        own_stb       = dcache_arb_stb;
        own_cyc       = dcache_arb_cyc;
        arb_mem_adr   = dcache_arb_adr;
        arb_mem_sel   = dcache_arb_sel;
        arb_mem_dat_m = dcache_arb_dat_m;
      end
      default: begin
        own_stb       = pf_arb_stb;
        own_cyc       = pf_arb_cyc;
        arb_mem_adr   = pf_arb_adr;
        arb_mem_sel   = pf_arb_sel;
        arb_mem_dat_m = pf_arb_dat_m;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wait_d       = wait_q;
    err_d        = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick_gnt) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          wait_d  = '0;
        end
      end
      ST_GRANT: begin
        // Any exit (ack, abort, timeout) rotates priority past this owner.
        if (!own_stb || arb_mem_ack || (wait_q == WAIT_LAST)) begin
          state_d      = ST_RELEASE;
          last_owner_d = owner_q;
          if (own_stb && !arb_mem_ack) begin
            err_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_IC;
      last_owner_q <= REQ_PF;
      wait_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
    end
  end

  assign in_grant    = (state_q == ST_GRANT);
  assign arb_mem_stb = in_grant & own_stb;
  assign arb_mem_cyc = in_grant & own_cyc;
  assign arb_mem_we  = in_grant & (owner_q == REQ_DC) & dcache_arb_we;
  assign ack_fwd     = in_grant & own_stb & arb_mem_ack;

  assign icache_arb_ack = ack_fwd & (owner_q == REQ_IC);
  assign dcache_arb_ack = ack_fwd & (owner_q == REQ_DC);
  assign pf_arb_ack     = ack_fwd & (owner_q == REQ_PF);

  assign icache_arb_rty = icache_arb_stb & ~icache_arb_ack;
  assign dcache_arb_rty = dcache_arb_stb & ~dcache_arb_ack;
  assign pf_arb_rty     = pf_arb_stb & ~pf_arb_ack;

  assign icache_arb_dat_s = arb_mem_dat_s;
  assign dcache_arb_dat_s = arb_mem_dat_s;
  assign pf_arb_dat_s     = arb_mem_dat_s;

  assign grant       = in_grant ? req_onehot(owner_q) : '0;
  assign timeout_err = err_q;

endmodule
